// File: rtl/cnt_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and default sizes.
package cnt_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_WRAPW = 8;

    localparam logic [1:0] ENC_IDLE  = 2'b00;
    localparam logic [1:0] ENC_RUN   = 2'b01;
    localparam logic [1:0] ENC_PAUSE = 2'b10;
    localparam logic [1:0] ENC_DONE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        RUN   = ENC_RUN,
        PAUSE = ENC_PAUSE,
        DONE  = ENC_DONE
    } state_t;

endpackage

// File: rtl/cnt_unit.sv
// WIDTH-bit up-counter register with synchronous clear/increment and compare against a limit.
module cnt_unit #(
    parameter int WIDTH = cnt_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero,
    output logic             o_match
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
    assign o_match = (r_count == i_limit);

endmodule

// File: rtl/mod_counter_sequencer.sv
// Start/pause/resume/abort sequencer for a binary up-counter with one-shot or auto-reload
// terminal handling, terminal-count pulse, done/ack handshake and saturating wrap count.
module mod_counter_sequencer
    import cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WRAPW = DEF_WRAPW
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_rl,
    input  logic [WIDTH-1:0] limit,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [WRAPW-1:0] wraps
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_limit_q;
    logic             r_auto_q;
    logic             r_tc;
    logic [WRAPW-1:0] r_wraps;

    logic [WIDTH-1:0] w_count;
    logic             w_zero;
    logic             w_match;

    logic             w_cnt_clear;
    logic             w_cnt_inc;
    logic             w_latch_cfg;
    logic             w_reload_limit;
    logic             w_tc_set;
    logic             w_wrap_inc;
    logic             w_wrap_clear;

    cnt_unit #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .clr     (clr),
        .i_clear (w_cnt_clear),
        .i_inc   (w_cnt_inc),
        .i_limit (r_limit_q),
        .o_count (w_count),
        .o_zero  (w_zero),
        .o_match (w_match)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next         = r_state;
        w_cnt_clear    = 1'b0;
        w_cnt_inc      = 1'b0;
        w_latch_cfg    = 1'b0;
        w_reload_limit = 1'b0;
        w_tc_set       = 1'b0;
        w_wrap_inc     = 1'b0;
        w_wrap_clear   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_next       = RUN;
                    w_cnt_clear  = !w_zero;
                    w_latch_cfg  = 1'b1;
                    w_wrap_clear = 1'b1;
                end
            end
            RUN: begin
                // stop takes priority: the edge that pauses performs no compare action
                if (stop) begin
                    w_next = PAUSE;
                end else if (w_match) begin
                    w_tc_set = 1'b1;
                    if (r_auto_q) begin
                        w_cnt_clear    = 1'b1;
                        w_reload_limit = 1'b1;
                        w_wrap_inc     = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    w_next      = IDLE;
                    w_cnt_clear = 1'b1;
                end else if (start) begin
                    w_next = RUN;
                end
            end
            DONE: begin
                if (ack) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // NOTE: all control registers take the async reset; none of them is a memory array.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_limit_q <= '0;
            r_auto_q  <= 1'b0;
            r_tc      <= 1'b0;
            r_wraps   <= '0;
        end else begin
            r_tc <= w_tc_set;
            if (w_latch_cfg) begin
                r_limit_q <= limit;
                r_auto_q  <= auto_rl;
            end else if (w_reload_limit) begin
                r_limit_q <= limit;
            end
            if (w_wrap_clear) begin
                r_wraps <= '0;
            end else if (w_wrap_inc && (r_wraps != '1)) begin
                r_wraps <= r_wraps + WRAPW'(1);
            end
        end
    end

    assign count = w_count;
    assign busy  = (r_state == RUN) || (r_state == PAUSE);
    assign done  = (r_state == DONE);
    assign tc    = r_tc;
    assign wraps = r_wraps;

endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Directed bench for mod_counter_sequencer: behavioural model compared every cycle plus literal checks.
module tb_mod_counter_sequencer;

    localparam int WIDTH = 4;
    localparam int WRAPW = 8;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             auto_rl = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;
    logic [WRAPW-1:0] wraps;

    int n_checks = 0;
    int n_fail   = 0;

    mod_counter_sequencer #(
        .WIDTH (WIDTH),
        .WRAPW (WRAPW)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .stop    (stop),
        .auto_rl (auto_rl),
        .limit   (limit),
        .ack     (ack),
        .count   (count),
        .busy    (busy),
        .tc      (tc),
        .done    (done),
        .wraps   (wraps)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: activity flags plus plain integer arithmetic.
    int m_count = 0;
    int m_limit = 0;
    int m_wraps = 0;
    bit m_auto = 0;
    bit m_active = 0;
    bit m_paused = 0;
    bit m_finished = 0;
    bit m_tc = 0;

    task automatic model_step();
        bit tc_now;
        if (!clr) begin
            m_count = 0; m_limit = 0; m_wraps = 0; m_auto = 0;
            m_active = 0; m_paused = 0; m_finished = 0; m_tc = 0;
            return;
        end
        tc_now = 0;
        if (m_finished) begin
            if (ack) m_finished = 0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1; m_paused = 0; m_count = 0; m_wraps = 0;
                m_limit = int'(limit); m_auto = auto_rl;
            end
        end else if (m_paused) begin
            if (stop) begin
                m_active = 0; m_paused = 0; m_count = 0;
            end else if (start) begin
                m_paused = 0;
            end
        end else if (stop) begin
            m_paused = 1;
        end else if (m_count == m_limit) begin
            tc_now = 1;
            if (m_auto) begin
                m_count = 0;
                m_limit = int'(limit);
                if (m_wraps < (1 << WRAPW) - 1) m_wraps = m_wraps + 1;
            end else begin
                m_active = 0;
                m_finished = 1;
            end
        end else begin
            m_count = (m_count + 1) % (1 << WIDTH);
        end
        m_tc = tc_now;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge clr);
            model_step();
        end
    end

    always @(negedge clk) begin
        check("model count", 32'(count), 32'(m_count));
        check("model busy",  32'(busy),  32'(m_active));
        check("model tc",    32'(tc),    32'(m_tc));
        check("model done",  32'(done),  32'(m_finished));
        check("model wraps", 32'(wraps), 32'(m_wraps));
    end

    task automatic drive(input logic st, input logic sp, input logic ar,
                         input logic [WIDTH-1:0] lm, input logic ak);
        start = st; stop = sp; auto_rl = ar; limit = lm; ack = ak;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        check("reset count", 32'(count), 32'd0);
        check("reset busy",  32'(busy),  32'd0);
        check("reset wraps", 32'(wraps), 32'd0);
        clr = 1'b1;

        // 1: asynchronous clear in the middle of a run
        drive(1, 0, 0, 4'd9, 0); step(1);
        check("t1 start count", 32'(count), 32'd0);
        drive(0, 0, 0, 4'd9, 0); step(5);
        check("t1 count5", 32'(count), 32'd5);
        #2 clr = 1'b0;
        #1;
        check("t1 clr count", 32'(count), 32'd0);
        check("t1 clr busy",  32'(busy),  32'd0);
        check("t1 clr tc",    32'(tc),    32'd0);
        check("t1 clr done",  32'(done),  32'd0);
        check("t1 clr wraps", 32'(wraps), 32'd0);
        @(negedge clk) clr = 1'b1;
        step(3);
        check("t1 post busy", 32'(busy), 32'd0);
        check("t1 post tc",   32'(tc),   32'd0);

        // 2: one-shot to 3 with done/ack handshake; start ignored in DONE
        drive(1, 0, 0, 4'd3, 0); step(1);
        check("t2 count0", 32'(count), 32'd0);
        drive(0, 0, 0, 4'd3, 0); step(3);
        check("t2 count3", 32'(count), 32'd3);
        check("t2 tc pre", 32'(tc), 32'd0);
        step(1);
        check("t2 tc",   32'(tc),   32'd1);
        check("t2 done", 32'(done), 32'd1);
        drive(1, 0, 0, 4'd3, 0); step(1);
        check("t2 tc once",  32'(tc),   32'd0);
        check("t2 done held", 32'(done), 32'd1);
        drive(0, 0, 0, 4'd3, 1); step(1);
        check("t2 ack done",  32'(done),  32'd0);
        check("t2 ack busy",  32'(busy),  32'd0);
        check("t2 ack count", 32'(count), 32'd3);
        drive(0, 0, 0, 4'd3, 0);

        // 3: auto-reload at 2, limit changed to 4 mid-run, ack ignored while running
        drive(1, 0, 1, 4'd2, 0); step(1);
        check("t3 count0", 32'(count), 32'd0);
        drive(0, 0, 1, 4'd2, 1); step(3);
        check("t3 wrap1 tc",    32'(tc),    32'd1);
        check("t3 wrap1 wraps", 32'(wraps), 32'd1);
        drive(0, 0, 1, 4'd2, 0); step(1);
        check("t3 count1", 32'(count), 32'd1);
        drive(0, 0, 1, 4'd4, 0); step(2);
        check("t3 wrap2 tc",    32'(tc),    32'd1);
        check("t3 wrap2 count", 32'(count), 32'd0);
        step(4);
        check("t3 count4", 32'(count), 32'd4);
        step(1);
        check("t3 wrap3 tc",    32'(tc),    32'd1);
        check("t3 wrap3 wraps", 32'(wraps), 32'd3);
        drive(0, 1, 1, 4'd4, 0); step(2);
        check("t3 abort busy", 32'(busy), 32'd0);
        drive(0, 0, 1, 4'd4, 0);

        // 4: pause at 6, resume to 7, abort from pause
        drive(1, 0, 0, 4'd9, 0); step(1);
        drive(0, 0, 0, 4'd9, 0); step(6);
        check("t4 count6", 32'(count), 32'd6);
        drive(0, 1, 0, 4'd9, 0); step(1);
        check("t4 paused count", 32'(count), 32'd6);
        check("t4 paused busy",  32'(busy),  32'd1);
        drive(0, 0, 0, 4'd9, 0); step(2);
        check("t4 frozen", 32'(count), 32'd6);
        drive(1, 0, 0, 4'd9, 0); step(1);
        check("t4 resume edge", 32'(count), 32'd6);
        drive(0, 0, 0, 4'd9, 0); step(1);
        check("t4 count7", 32'(count), 32'd7);
        drive(0, 1, 0, 4'd9, 0); step(2);
        check("t4 abort count", 32'(count), 32'd0);
        check("t4 abort busy",  32'(busy),  32'd0);
        check("t4 abort tc",    32'(tc),    32'd0);
        check("t4 abort done",  32'(done),  32'd0);

        // 5: tie in IDLE, limit=0 one-shot, limit=15 auto, wrap saturation
        drive(1, 1, 0, 4'd5, 0); step(1);
        check("t5 tie busy", 32'(busy), 32'd0);
        drive(1, 0, 0, 4'd0, 0); step(1);
        check("t5 l0 busy", 32'(busy), 32'd1);
        drive(0, 0, 0, 4'd0, 0); step(1);
        check("t5 l0 tc",   32'(tc),   32'd1);
        check("t5 l0 done", 32'(done), 32'd1);
        drive(0, 0, 0, 4'd0, 1); step(1);
        check("t5 l0 ack", 32'(done), 32'd0);
        drive(1, 0, 1, 4'd15, 0); step(1);
        drive(0, 0, 1, 4'd15, 0); step(15);
        check("t5 l15 count15", 32'(count), 32'd15);
        step(1);
        check("t5 l15 wrap count", 32'(count), 32'd0);
        check("t5 l15 tc",         32'(tc),    32'd1);
        drive(0, 1, 1, 4'd15, 0); step(2);
        drive(1, 0, 1, 4'd0, 0); step(1);
        check("t5 sat wraps0", 32'(wraps), 32'd0);
        drive(0, 0, 1, 4'd0, 0); step(255);
        check("t5 sat 255", 32'(wraps), 32'd255);
        step(5);
        check("t5 sat hold", 32'(wraps), 32'hFF);
        check("t5 sat tc",   32'(tc),    32'd1);
        drive(0, 1, 1, 4'd0, 0); step(2);
        check("t5 end busy", 32'(busy), 32'd0);
        drive(0, 0, 0, 4'd0, 0); step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
